// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for the 64K x 16 data memory.
// Ports: r0_* (fetch) / r1_* (load-store) request side, mem_* memory side.
module mem_arbiter #(
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic        r0_lock,
    input  logic [15:0] r0_addr,
    input  logic [15:0] r0_wdata,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic        r1_lock,
    input  logic [15:0] r1_addr,
    input  logic [15:0] r1_wdata,
    output logic        r0_gnt,
    output logic        r1_gnt,
    output logic        r0_rvalid,
    output logic        r1_rvalid,
    output logic [15:0] r0_rdata,
    output logic [15:0] r1_rdata,
    output logic        mem_write,
    output logic [15:0] mem_write_address,
    output logic [15:0] mem_write_input,
    output logic [15:0] mem_read_address,
    input  logic [15:0] mem_read_output
);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    localparam logic [3:0] LMAX = 4'(LOCK_MAX);

    state_t      r_state;
    logic        r_owner;
    logic        r_last;
    logic [3:0]  r_lock_cnt;

    logic        w_own_req;
    logic        w_hold;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_gnt;
    logic        w_win;
    logic        w_win_we;
    logic        w_win_lock;
    logic [15:0] w_win_addr;
    logic [15:0] w_win_wdata;
    logic [3:0]  w_cnt_nxt;

    always_comb begin
        w_own_req = r_owner ? r1_req : r0_req;
        // A locked owner that stopped requesting falls back to IDLE rules now.
        w_hold    = (r_state == S_LOCKED) && w_own_req;
        w_gnt0    = 1'b0;
        w_gnt1    = 1'b0;
        if (!rst_n) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end else if (w_hold) begin
            w_gnt0 = !r_owner;
            w_gnt1 = r_owner;
        end else if (r0_req && r1_req) begin
            w_gnt0 = r_last;
            w_gnt1 = !r_last;
        end else begin
            w_gnt0 = r0_req;
            w_gnt1 = r1_req;
        end
        w_gnt       = w_gnt0 | w_gnt1;
        w_win       = w_gnt1;
        w_win_we    = w_win ? r1_we    : r0_we;
        w_win_lock  = w_win ? r1_lock  : r0_lock;
        w_win_addr  = w_win ? r1_addr  : r0_addr;
        w_win_wdata = w_win ? r1_wdata : r0_wdata;
        w_cnt_nxt   = r_lock_cnt + 4'd1;
    end

    assign r0_gnt            = w_gnt0;
    assign r1_gnt            = w_gnt1;
    assign mem_write         = w_gnt & w_win_we;
    assign mem_write_address = w_gnt ? w_win_addr  : 16'h0000;
    assign mem_write_input   = w_gnt ? w_win_wdata : 16'h0000;
    assign mem_read_address  = w_gnt ? w_win_addr  : 16'h0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_lock_cnt <= 4'd0;
            r0_rvalid  <= 1'b0;
            r1_rvalid  <= 1'b0;
            r0_rdata   <= 16'h0000;
            r1_rdata   <= 16'h0000;
        end else begin
            r0_rvalid <= w_gnt0 & !r0_we;
            r1_rvalid <= w_gnt1 & !r1_we;
            if (w_gnt0 && !r0_we) begin
                r0_rdata <= mem_read_output;
            end
            if (w_gnt1 && !r1_we) begin
                r1_rdata <= mem_read_output;
            end
            if (w_gnt) begin
                r_last <= w_win;
            end
            if (w_hold) begin
                // Owner keeps going until it drops lock or hits the bound.
                if (!w_win_lock || (w_cnt_nxt >= LMAX)) begin
                    r_state    <= S_IDLE;
                    r_lock_cnt <= 4'd0;
                end else begin
                    r_lock_cnt <= w_cnt_nxt;
                end
            end else if (w_gnt && w_win_lock && (LMAX > 4'd1)) begin
                r_state    <= S_LOCKED;
                r_owner    <= w_win;
                r_lock_cnt <= 4'd1;
            end else begin
                r_state    <= S_IDLE;
                r_lock_cnt <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed vector table plus reset sequences.
// Models the 64K x 16 memory with a write-at-edge, combinational-read array.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        r0_req, r0_we, r0_lock;
    logic [15:0] r0_addr, r0_wdata;
    logic        r1_req, r1_we, r1_lock;
    logic [15:0] r1_addr, r1_wdata;
    logic        r0_gnt, r1_gnt;
    logic        r0_rvalid, r1_rvalid;
    logic [15:0] r0_rdata, r1_rdata;
    logic        mem_write;
    logic [15:0] mem_write_address;
    logic [15:0] mem_write_input;
    logic [15:0] mem_read_address;
    logic [15:0] mem_read_output;

    logic [15:0] mem [0:65535];

    int n_total;
    int n_pass;

    mem_arbiter #(.LOCK_MAX(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .r0_req            (r0_req),
        .r0_we             (r0_we),
        .r0_lock           (r0_lock),
        .r0_addr           (r0_addr),
        .r0_wdata          (r0_wdata),
        .r1_req            (r1_req),
        .r1_we             (r1_we),
        .r1_lock           (r1_lock),
        .r1_addr           (r1_addr),
        .r1_wdata          (r1_wdata),
        .r0_gnt            (r0_gnt),
        .r1_gnt            (r1_gnt),
        .r0_rvalid         (r0_rvalid),
        .r1_rvalid         (r1_rvalid),
        .r0_rdata          (r0_rdata),
        .r1_rdata          (r1_rdata),
        .mem_write         (mem_write),
        .mem_write_address (mem_write_address),
        .mem_write_input   (mem_write_input),
        .mem_read_address  (mem_read_address),
        .mem_read_output   (mem_read_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write) mem[mem_write_address] <= mem_write_input;
    end
    assign mem_read_output = mem[mem_read_address];

    // c0/c1 = {req, we, lock}; gnt = {g1, g0}; rv = {rv1, rv0}.
    // rv/rd are the registered outputs visible before this row's edge.
    typedef struct packed {
        logic [2:0]  c0;
        logic [15:0] a0;
        logic [15:0] d0;
        logic [2:0]  c1;
        logic [15:0] a1;
        logic [15:0] d1;
        logic [1:0]  gnt;
        logic        mw;
        logic [15:0] mwa;
        logic [15:0] mwd;
        logic [15:0] mra;
        logic [1:0]  rv;
        logic [15:0] rd0;
        logic [15:0] rd1;
    } vec_t;

    localparam logic [2:0] N  = 3'b000;
    localparam logic [2:0] RD = 3'b100;
    localparam logic [2:0] WR = 3'b110;
    localparam logic [2:0] RL = 3'b101;

    localparam int NV = 27;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic apply(input vec_t v);
        {r0_req, r0_we, r0_lock} = v.c0;
        r0_addr  = v.a0;
        r0_wdata = v.d0;
        {r1_req, r1_we, r1_lock} = v.c1;
        r1_addr  = v.a1;
        r1_wdata = v.d1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;

        tbl[0]  = '{WR, 16'h0010, 16'hA5A5, WR, 16'h0020, 16'h5A5A,
                    2'b01, 1'b1, 16'h0010, 16'hA5A5, 16'h0010,
                    2'b00, 16'h0000, 16'h0000};
        tbl[1]  = '{N, 16'h0000, 16'h0000, WR, 16'h0020, 16'h5A5A,
                    2'b10, 1'b1, 16'h0020, 16'h5A5A, 16'h0020,
                    2'b00, 16'h0000, 16'h0000};
        tbl[2]  = '{RD, 16'h0010, 16'h1111, WR, 16'h1234, 16'hBEEF,
                    2'b01, 1'b0, 16'h0010, 16'h1111, 16'h0010,
                    2'b00, 16'h0000, 16'h0000};
        tbl[3]  = '{N, 16'h0000, 16'h0000, WR, 16'h1234, 16'hBEEF,
                    2'b10, 1'b1, 16'h1234, 16'hBEEF, 16'h1234,
                    2'b01, 16'hA5A5, 16'h0000};
        tbl[4]  = '{N, 16'h0000, 16'h0000, RD, 16'h1234, 16'h0000,
                    2'b10, 1'b0, 16'h1234, 16'h0000, 16'h1234,
                    2'b00, 16'hA5A5, 16'h0000};
        tbl[5]  = '{N, 16'h0000, 16'h0000, N, 16'h0000, 16'h0000,
                    2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000,
                    2'b10, 16'hA5A5, 16'hBEEF};
        tbl[6]  = '{RD, 16'h0010, 16'h1111, RD, 16'h0020, 16'h2222,
                    2'b01, 1'b0, 16'h0010, 16'h1111, 16'h0010,
                    2'b00, 16'hA5A5, 16'hBEEF};
        tbl[7]  = '{RD, 16'h0010, 16'h1111, RD, 16'h0020, 16'h2222,
                    2'b10, 1'b0, 16'h0020, 16'h2222, 16'h0020,
                    2'b01, 16'hA5A5, 16'hBEEF};
        for (int k = 8; k <= 11; k++) begin
            tbl[k] = '{RD, 16'h0010, 16'h1111, RD, 16'h0020, 16'h2222,
                       2'b01, 1'b0, 16'h0010, 16'h1111, 16'h0010,
                       2'b10, 16'hA5A5, 16'h5A5A};
            if (k % 2 == 1) begin
                tbl[k].gnt = 2'b10;
                tbl[k].mwa = 16'h0020;
                tbl[k].mwd = 16'h2222;
                tbl[k].mra = 16'h0020;
                tbl[k].rv  = 2'b01;
            end
        end
        tbl[12] = '{RD, 16'h0010, 16'h1111, N, 16'h0000, 16'h0000,
                    2'b01, 1'b0, 16'h0010, 16'h1111, 16'h0010,
                    2'b10, 16'hA5A5, 16'h5A5A};
        for (int k = 13; k <= 18; k++) begin
            tbl[k] = '{RD, 16'h0010, 16'h1111, RL, 16'h0020, 16'h2222,
                       2'b10, 1'b0, 16'h0020, 16'h2222, 16'h0020,
                       2'b10, 16'hA5A5, 16'h5A5A};
        end
        tbl[13].rv  = 2'b01;
        tbl[17].gnt = 2'b01;
        tbl[17].mwa = 16'h0010;
        tbl[17].mwd = 16'h1111;
        tbl[17].mra = 16'h0010;
        tbl[18].rv  = 2'b01;
        tbl[19] = '{N, 16'h0000, 16'h0000, RD, 16'h0020, 16'h2222,
                    2'b10, 1'b0, 16'h0020, 16'h2222, 16'h0020,
                    2'b10, 16'hA5A5, 16'h5A5A};
        tbl[20] = '{RL, 16'h0010, 16'h1111, RD, 16'h0020, 16'h2222,
                    2'b01, 1'b0, 16'h0010, 16'h1111, 16'h0010,
                    2'b10, 16'hA5A5, 16'h5A5A};
        tbl[21] = '{RD, 16'h0010, 16'h1111, RD, 16'h0020, 16'h2222,
                    2'b01, 1'b0, 16'h0010, 16'h1111, 16'h0010,
                    2'b01, 16'hA5A5, 16'h5A5A};
        tbl[22] = '{RD, 16'h0010, 16'h1111, RD, 16'h0020, 16'h2222,
                    2'b10, 1'b0, 16'h0020, 16'h2222, 16'h0020,
                    2'b01, 16'hA5A5, 16'h5A5A};
        tbl[23] = '{N, 16'h0000, 16'h0000, N, 16'h0000, 16'h0000,
                    2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000,
                    2'b10, 16'hA5A5, 16'h5A5A};
        tbl[24] = '{RL, 16'h0010, 16'h1111, N, 16'h0000, 16'h0000,
                    2'b01, 1'b0, 16'h0010, 16'h1111, 16'h0010,
                    2'b00, 16'hA5A5, 16'h5A5A};
        tbl[25] = '{N, 16'h0000, 16'h0000, RD, 16'h0020, 16'h2222,
                    2'b10, 1'b0, 16'h0020, 16'h2222, 16'h0020,
                    2'b01, 16'hA5A5, 16'h5A5A};
        tbl[26] = '{N, 16'h0000, 16'h0000, N, 16'h0000, 16'h0000,
                    2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000,
                    2'b10, 16'hA5A5, 16'h5A5A};

        // Reset held with both requesters asking for writes.
        rst_n = 1'b0;
        apply('{WR, 16'h0010, 16'hA5A5, WR, 16'h0020, 16'h5A5A,
                2'b00, 1'b0, 16'h0, 16'h0, 16'h0, 2'b00, 16'h0, 16'h0});
        #2;
        chk("rst_g0", 16'(r0_gnt), 16'h0);
        chk("rst_g1", 16'(r1_gnt), 16'h0);
        chk("rst_mw", 16'(mem_write), 16'h0);
        chk("rst_rv0", 16'(r0_rvalid), 16'h0);
        chk("rst_rv1", 16'(r1_rvalid), 16'h0);
        chk("rst_rd0", r0_rdata, 16'h0);
        chk("rst_rd1", r1_rdata, 16'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            apply(tbl[i]);
            #1;
            chk($sformatf("v%0d_g0", i), 16'(r0_gnt), 16'(tbl[i].gnt[0]));
            chk($sformatf("v%0d_g1", i), 16'(r1_gnt), 16'(tbl[i].gnt[1]));
            chk($sformatf("v%0d_mw", i), 16'(mem_write), 16'(tbl[i].mw));
            chk($sformatf("v%0d_mwa", i), mem_write_address, tbl[i].mwa);
            chk($sformatf("v%0d_mwd", i), mem_write_input, tbl[i].mwd);
            chk($sformatf("v%0d_mra", i), mem_read_address, tbl[i].mra);
            chk($sformatf("v%0d_rv0", i), 16'(r0_rvalid), 16'(tbl[i].rv[0]));
            chk($sformatf("v%0d_rv1", i), 16'(r1_rvalid), 16'(tbl[i].rv[1]));
            chk($sformatf("v%0d_rd0", i), r0_rdata, tbl[i].rd0);
            chk($sformatf("v%0d_rd1", i), r1_rdata, tbl[i].rd1);
        end

        // Reset in the middle of r1's locked read burst.
        @(negedge clk);
        apply('{N, 16'h0000, 16'h0000, RL, 16'h0020, 16'h2222,
                2'b00, 1'b0, 16'h0, 16'h0, 16'h0, 2'b00, 16'h0, 16'h0});
        #1;
        chk("rml_g1_first", 16'(r1_gnt), 16'h1);
        @(negedge clk);
        #1;
        chk("rml_g1_second", 16'(r1_gnt), 16'h1);
        chk("rml_rv1_first", 16'(r1_rvalid), 16'h1);
        #1;
        rst_n = 1'b0;
        r0_req  = 1'b1;
        r0_addr = 16'h0010;
        #1;
        chk("rml_rst_g0", 16'(r0_gnt), 16'h0);
        chk("rml_rst_g1", 16'(r1_gnt), 16'h0);
        chk("rml_rst_mw", 16'(mem_write), 16'h0);
        chk("rml_rst_rv1", 16'(r1_rvalid), 16'h0);
        chk("rml_rst_rd1", r1_rdata, 16'h0);
        @(negedge clk);
        #1;
        chk("rml_no_rv1", 16'(r1_rvalid), 16'h0);
        rst_n = 1'b1;
        #1;
        chk("rml_post_g0", 16'(r0_gnt), 16'h1);
        chk("rml_post_g1", 16'(r1_gnt), 16'h0);
        @(negedge clk);
        #1;
        chk("rml_post_rv0", 16'(r0_rvalid), 16'h1);
        chk("rml_post_rd0", r0_rdata, 16'hA5A5);
        chk("rml_post_rv1", 16'(r1_rvalid), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
